// File: rtl/cop1_seq_pkg.sv
// Shared types and constants for the COP1 memory sequencer.
// FSM encoding, beat-count constants, FP register file geometry.
package cop1_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } fsm_t;

    localparam int BEATS_SINGLE = 1;
    localparam int BEATS_DOUBLE = 2;
    localparam int FREG_COUNT   = 32;
    localparam int FREG_IDX_W   = $clog2(FREG_COUNT);

    function automatic int beat_w(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/cop1_seq_addr_gen.sv
// Beat address generator: word address and FP register index for beat k, both wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module cop1_seq_addr_gen
    import cop1_seq_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int BEAT_W = 2
) (
    input  logic [ADDR_W-1:0]     base_a,
    input  logic [FREG_IDX_W-1:0] base_idx,
    input  logic [BEAT_W-1:0]     k,
    output logic [ADDR_W-1:0]     a,
    output logic [FREG_IDX_W-1:0] idx
);

    assign a   = base_a + ADDR_W'(k);
    assign idx = base_idx + FREG_IDX_W'(k);

endmodule

// File: rtl/cop1_mem_sequencer.sv
// COP1 multi-beat load/store sequencer; optional alignment checks under COP1_SEQ_ALIGN_CHECK_EN.
// Latency: N cycles (stores, 0-latency loads) or N+1 cycles (1-latency loads), first beat with no bubble.
// Backpressure: stall holds the core's PC/IR until the final beat; the request must stay stable meanwhile.
module cop1_mem_sequencer
    import cop1_seq_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int MAX_BEATS  = 2,
    parameter int MEM_RD_LAT = 0,
    parameter int BEAT_W     = beat_w(MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_store,
    input  logic [BEAT_W-1:0]     req_beats,
    input  logic [31:0]           req_byte_addr,
    input  logic [FREG_IDX_W-1:0] req_freg,
    output logic                  stall,
    output logic                  done,
    output logic                  err_misalign,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic                  mem_oen,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [FREG_IDX_W-1:0] freg_rd_idx,
    input  logic [DATA_W-1:0]     freg_rd_data,
    output logic                  freg_we,
    output logic [FREG_IDX_W-1:0] freg_wr_idx,
    output logic [DATA_W-1:0]     freg_wr_data
);

    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    fsm_t              state_q, state_d;
    logic [BEAT_W-1:0] iss_k_q, iss_k_d;
    logic [BEAT_W-1:0] cap_k_q, cap_k_d;

    logic                  lat1_load;
    logic                  beats_over;
    logic                  beats_zero;
    logic                  align_bad;
    logic                  reject;
    logic [BEAT_W-1:0]     iss_k;
    logic                  last_iss;
    logic                  iss_en;
    logic                  cap_en;
    logic [FREG_IDX_W-1:0] iss_idx;
    logic [FREG_IDX_W-1:0] cap_idx;
    logic [ADDR_W-1:0]     cap_a_unused;
    logic                  unused_addr_bits;

    assign lat1_load  = !req_store && (MEM_RD_LAT == 1);
    assign beats_over = int'(req_beats) > MAX_BEATS;
    assign beats_zero = (req_beats == '0);

`ifdef COP1_SEQ_ALIGN_CHECK_EN
    assign align_bad = (req_byte_addr[1:0] != 2'b00) ||
                       ((int'(req_beats) == BEATS_DOUBLE) && req_freg[0]);
    assign unused_addr_bits = ^req_byte_addr[31:ADDR_W+2];
`else
    assign align_bad = 1'b0;
    assign unused_addr_bits = ^{req_byte_addr[31:ADDR_W+2], req_byte_addr[1:0]};
`endif

    assign reject   = beats_over | align_bad;
    // Beat 0 issues straight out of IDLE, so the issue index is forced to zero there.
    assign iss_k    = (state_q == IDLE) ? '0 : iss_k_q;
    assign last_iss = (iss_k == req_beats - BEAT_ONE);

    cop1_seq_addr_gen #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) u_iss_gen (
        .base_a   (req_byte_addr[ADDR_W+1:2]),
        .base_idx (req_freg),
        .k        (iss_k),
        .a        (mem_a),
        .idx      (iss_idx)
    );

    cop1_seq_addr_gen #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) u_cap_gen (
        .base_a   (req_byte_addr[ADDR_W+1:2]),
        .base_idx (req_freg),
        .k        (cap_k_q),
        .a        (cap_a_unused),
        .idx      (cap_idx)
    );

    always_comb begin
        state_d      = state_q;
        iss_k_d      = iss_k_q;
        cap_k_d      = cap_k_q;
        iss_en       = 1'b0;
        cap_en       = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        err_misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reject) begin
                        err_misalign = 1'b1;
                        done         = 1'b1;
                    end else if (beats_zero) begin
                        done = 1'b1;
                    end else begin
                        iss_en = 1'b1;
                        if (lat1_load || !last_iss) begin
                            stall   = 1'b1;
                            state_d = XFER;
                            iss_k_d = BEAT_ONE;
                            cap_k_d = '0;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
            end
            XFER: begin
                if (lat1_load) begin
                    cap_en  = 1'b1;
                    cap_k_d = cap_k_q + BEAT_ONE;
                    if (iss_k_q < req_beats) begin
                        iss_en  = 1'b1;
                        stall   = 1'b1;
                        iss_k_d = iss_k_q + BEAT_ONE;
                        if (last_iss) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        // Single-beat pipelined load: this cycle is capture-only.
                        done    = 1'b1;
                        state_d = IDLE;
                        iss_k_d = '0;
                        cap_k_d = '0;
                    end
                end else begin
                    iss_en = 1'b1;
                    if (last_iss) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        iss_k_d = '0;
                    end else begin
                        stall   = 1'b1;
                        iss_k_d = iss_k_q + BEAT_ONE;
                    end
                end
            end
            DRAIN: begin
                cap_en  = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
                iss_k_d = '0;
                cap_k_d = '0;
            end
            default: begin
                state_d = IDLE;
                iss_k_d = '0;
                cap_k_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            iss_k_q <= '0;
            cap_k_q <= '0;
        end else begin
            state_q <= state_d;
            iss_k_q <= iss_k_d;
            cap_k_q <= cap_k_d;
        end
    end

    assign mem_wen      = !(iss_en && req_store);
    assign mem_oen      = !(iss_en && !req_store);
    assign mem_cen      = mem_oen & mem_wen;
    assign mem_wdata    = freg_rd_data;
    assign freg_rd_idx  = iss_idx;
    assign freg_we      = lat1_load ? cap_en : (iss_en && !req_store);
    assign freg_wr_idx  = lat1_load ? cap_idx : iss_idx;
    assign freg_wr_data = mem_rdata;

endmodule

// File: tb/tb_cop1_mem_sequencer.sv
// Directed bench for cop1_mem_sequencer: one instance with 0-cycle and one with 1-cycle read latency,
// each attached to its own word memory and FP register file model.
module tb_cop1_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid0, req_valid1;
    logic        req_store;
    logic [1:0]  req_beats;
    logic [31:0] req_byte_addr;
    logic [4:0]  req_freg;

    logic        stall0, done0, err0, cen0, wen0, oen0, fwe0;
    logic [6:0]  a0;
    logic [31:0] wdata0, rdata0, rd_data0, wr_data0;
    logic [4:0]  rd_idx0, wr_idx0;

    logic        stall1, done1, err1, cen1, wen1, oen1, fwe1;
    logic [6:0]  a1;
    logic [31:0] wdata1, rdata1, rd_data1, wr_data1;
    logic [4:0]  rd_idx1, wr_idx1;

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [128];
    logic [31:0] freg0 [32];
    logic [31:0] freg1 [32];

    logic        bk_mem_we, bk_freg_we;
    logic [6:0]  bk_idx;
    logic [31:0] bk_dat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cop1_mem_sequencer #(.DATA_W(32), .ADDR_W(7), .MAX_BEATS(2), .MEM_RD_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_store(req_store),
        .req_beats(req_beats), .req_byte_addr(req_byte_addr), .req_freg(req_freg),
        .stall(stall0), .done(done0), .err_misalign(err0),
        .mem_cen(cen0), .mem_wen(wen0), .mem_oen(oen0), .mem_a(a0),
        .mem_wdata(wdata0), .mem_rdata(rdata0),
        .freg_rd_idx(rd_idx0), .freg_rd_data(rd_data0),
        .freg_we(fwe0), .freg_wr_idx(wr_idx0), .freg_wr_data(wr_data0)
    );

    cop1_mem_sequencer #(.DATA_W(32), .ADDR_W(7), .MAX_BEATS(2), .MEM_RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_store(req_store),
        .req_beats(req_beats), .req_byte_addr(req_byte_addr), .req_freg(req_freg),
        .stall(stall1), .done(done1), .err_misalign(err1),
        .mem_cen(cen1), .mem_wen(wen1), .mem_oen(oen1), .mem_a(a1),
        .mem_wdata(wdata1), .mem_rdata(rdata1),
        .freg_rd_idx(rd_idx1), .freg_rd_data(rd_data1),
        .freg_we(fwe1), .freg_wr_idx(wr_idx1), .freg_wr_data(wr_data1)
    );

    assign rdata0   = mem0[a0];
    assign rd_data0 = freg0[rd_idx0];
    assign rd_data1 = freg1[rd_idx1];

    always @(posedge clk) begin
        if (bk_mem_we) begin
            mem0[bk_idx] <= bk_dat;
            mem1[bk_idx] <= bk_dat;
        end
        if (bk_freg_we) begin
            freg0[bk_idx[4:0]] <= bk_dat;
            freg1[bk_idx[4:0]] <= bk_dat;
        end
        if (!wen0) mem0[a0] <= wdata0;
        if (fwe0)  freg0[wr_idx0] <= wr_data0;
        if (!wen1) mem1[a1] <= wdata1;
        if (fwe1)  freg1[wr_idx1] <= wr_data1;
        if (!oen1) rdata1 <= mem1[a1];
    end

    // The core must hold req_valid for as long as stall was high in an active cycle.
    logic prev_stall0 = 1'b0;
    logic prev_stall1 = 1'b0;
    always @(posedge clk) begin
        if (rst_n && prev_stall0) assert (req_valid0) else $error("req_valid0 dropped under stall");
        if (rst_n && prev_stall1) assert (req_valid1) else $error("req_valid1 dropped under stall");
        prev_stall0 <= stall0 && rst_n;
        prev_stall1 <= stall1 && rst_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_mem(input int idx, input logic [31:0] d);
        bk_mem_we = 1'b1;
        bk_idx    = 7'(idx);
        bk_dat    = d;
        tick();
        bk_mem_we = 1'b0;
    endtask

    task automatic poke_freg(input int idx, input logic [31:0] d);
        bk_freg_we = 1'b1;
        bk_idx     = 7'(idx);
        bk_dat     = d;
        tick();
        bk_freg_we = 1'b0;
    endtask

    task automatic set_req(input logic st, input logic [1:0] n, input logic [31:0] ad, input logic [4:0] ft);
        req_store     = st;
        req_beats     = n;
        req_byte_addr = ad;
        req_freg      = ft;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        bk_mem_we  = 1'b0;
        bk_freg_we = 1'b0;
        bk_idx = '0;
        bk_dat = '0;
        set_req(1'b0, 2'd0, 32'h0, 5'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst_stall0", stall0, 0);
        check("rst_done0",  done0,  0);
        check("rst_err0",   err0,   0);
        check("rst_strb0",  {cen0, wen0, oen0}, 3'b111);
        check("rst_fwe0",   fwe0,   0);
        check("rst_strb1",  {stall1, done1, cen1, wen1, oen1, fwe1}, 6'b001110);

        // Single load, 0-cycle latency
        poke_mem(4, 32'h3F80_0000);
        set_req(1'b0, 2'd1, 32'h10, 5'd4);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("ld1_a",    a0, 4);
        check("ld1_oen",  oen0, 0);
        check("ld1_we",   fwe0, 1);
        check("ld1_idx",  wr_idx0, 4);
        check("ld1_data", wr_data0, 32'h3F80_0000);
        check("ld1_done", {done0, stall0}, 2'b10);
        tick();
        req_valid0 = 1'b0;
        check("ld1_freg", freg0[4], 32'h3F80_0000);

        // Double store
        poke_freg(6, 32'h4000_0000);
        poke_freg(7, 32'h0);
        poke_mem(9, 32'hDEAD_BEEF);
        set_req(1'b1, 2'd2, 32'h20, 5'd6);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("st2_a0",  a0, 8);
        check("st2_w0",  {wen0, oen0, cen0}, 3'b010);
        check("st2_d0",  wdata0, 32'h4000_0000);
        check("st2_s0",  {stall0, done0}, 2'b10);
        tick();
        @(negedge clk);
        check("st2_a1",  a0, 9);
        check("st2_d1",  wdata0, 32'h0);
        check("st2_s1",  {stall0, done0}, 2'b01);
        tick();
        req_valid0 = 1'b0;
        check("st2_m8",  mem0[8], 32'h4000_0000);
        check("st2_m9",  mem0[9], 32'h0);

        // Double store with FP register index wrap (Ft=31 -> 0)
        set_req(1'b1, 2'd2, 32'h0, 5'd31);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("wrap_r0", rd_idx0, 31);
        tick();
        @(negedge clk);
        check("wrap_r1", {rd_idx0, a0}, {5'd0, 7'd1});
        check("wrap_dn", done0, 1);
        tick();
        req_valid0 = 1'b0;

        // Double load, 1-cycle latency, word address wraps 127 -> 0
        poke_mem(127, 32'h1111_1111);
        poke_mem(0,   32'h2222_2222);
        set_req(1'b0, 2'd2, 32'h1FC, 5'd10);
        req_valid1 = 1'b1;
        @(negedge clk);
        check("ldp_c0",  {a1, oen1, fwe1, stall1, done1}, {7'd127, 4'b0010});
        tick();
        @(negedge clk);
        check("ldp_c1",  {a1, oen1, fwe1, stall1, done1}, {7'd0, 4'b0110});
        check("ldp_i1",  wr_idx1, 10);
        check("ldp_d1",  wr_data1, 32'h1111_1111);
        tick();
        @(negedge clk);
        check("ldp_c2",  {oen1, cen1, fwe1, stall1, done1}, 5'b11101);
        check("ldp_i2",  wr_idx1, 11);
        check("ldp_d2",  wr_data1, 32'h2222_2222);
        tick();
        req_valid1 = 1'b0;
        check("ldp_f10", freg1[10], 32'h1111_1111);
        check("ldp_f11", freg1[11], 32'h2222_2222);

        // Single load, 1-cycle latency: issue then capture
        poke_mem(2, 32'h0BAD_F00D);
        set_req(1'b0, 2'd1, 32'h08, 5'd1);
        req_valid1 = 1'b1;
        @(negedge clk);
        check("ls1_c0",  {oen1, fwe1, stall1, done1}, 4'b0010);
        tick();
        @(negedge clk);
        check("ls1_c1",  {oen1, fwe1, stall1, done1}, 4'b1101);
        check("ls1_d",   {wr_idx1, wr_data1}, {5'd1, 32'h0BAD_F00D});
        tick();
        req_valid1 = 1'b0;

        // Reset during cycle 1 of a pipelined double load
        poke_mem(16, 32'hAAAA_0001);
        poke_mem(17, 32'hAAAA_0002);
        poke_freg(20, 32'h5555_5555);
        poke_freg(21, 32'h5555_5555);
        set_req(1'b0, 2'd2, 32'h40, 5'd20);
        req_valid1 = 1'b1;
        @(negedge clk);
        check("rmid_c0", oen1, 0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rmid_c1", {done1, fwe1}, 2'b01);
        tick();
        rst_n = 1'b1;
        req_valid1 = 1'b0;
        @(negedge clk);
        check("rmid_idle", {stall1, done1, cen1, wen1, oen1, fwe1}, 6'b001110);
        check("rmid_f20", freg1[20], 32'hAAAA_0001);
        check("rmid_f21", freg1[21], 32'h5555_5555);

        // Zero-beat and over-length requests
        set_req(1'b0, 2'd0, 32'h40, 5'd3);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("zero",  {done0, err0, stall0, cen0, fwe0}, 5'b10010);
        tick();
        set_req(1'b1, 2'd3, 32'h40, 5'd3);
        @(negedge clk);
        check("over",  {done0, err0, stall0, cen0, wen0}, 5'b11011);
        tick();
        req_valid0 = 1'b0;

`ifdef COP1_SEQ_ALIGN_CHECK_EN
        set_req(1'b0, 2'd1, 32'h22, 5'd4);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("al_addr", {done0, err0, stall0, cen0, fwe0}, 5'b11010);
        tick();
        set_req(1'b0, 2'd2, 32'h30, 5'd5);
        @(negedge clk);
        check("al_odd",  {done0, err0, stall0, cen0, fwe0}, 5'b11010);
        tick();
        req_valid0 = 1'b0;
`else
        set_req(1'b0, 2'd1, 32'h22, 5'd4);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("na_addr", {a0, oen0, err0, done0}, {7'd8, 3'b001});
        tick();
        set_req(1'b1, 2'd2, 32'h30, 5'd5);
        @(negedge clk);
        check("na_odd0", {rd_idx0, wen0, err0, stall0}, {5'd5, 3'b001});
        tick();
        @(negedge clk);
        check("na_odd1", {rd_idx0, done0}, {5'd6, 1'b1});
        tick();
        req_valid0 = 1'b0;
`endif

        // Back-to-back double store then double load, no idle cycle
        poke_freg(2, 32'hCAFE_0002);
        poke_freg(3, 32'hCAFE_0003);
        set_req(1'b1, 2'd2, 32'h50, 5'd2);
        req_valid0 = 1'b1;
        @(negedge clk);
        check("b2b_s0", {a0, wen0, stall0}, {7'd20, 2'b01});
        tick();
        @(negedge clk);
        check("b2b_s1", {a0, done0}, {7'd21, 1'b1});
        tick();
        req_store = 1'b0;
        @(negedge clk);
        check("b2b_l0", {a0, oen0, fwe0, stall0}, {7'd20, 3'b011});
        check("b2b_d0", wr_data0, 32'hCAFE_0002);
        tick();
        @(negedge clk);
        check("b2b_l1", {wr_idx0, done0, stall0}, {5'd3, 2'b10});
        check("b2b_d1", wr_data0, 32'hCAFE_0003);
        tick();
        req_valid0 = 1'b0;
        check("b2b_f3", freg0[3], 32'hCAFE_0003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cop1_mem_sequencer.md
Name: cop1_mem_sequencer

Overview:
Multi-beat load/store sequencer for the coprocessor-1 (FPU) register file. It replaces the single-purpose double-stall logic of the single-cycle core. It splits any COP1 memory transfer (lwc1/swc1 = 1 beat, ldc1/sdc1 = 2 beats, up to MAX_BEATS) into word beats on the data-memory port. It stalls the core's PC until the last beat completes and supports 0- or 1-cycle memory read latency.

Parameters:
DATA_W, 32, FP register/memory word width
ADDR_W, 7, memory word-address width (mem_a)
MAX_BEATS, 2, max words per transfer (>=1)
MEM_RD_LAT, 0, memory read latency in cycles (0 = rdata valid in the same cycle as OEN low; 1 = next cycle)
BEAT_W, $clog2(MAX_BEATS+1), width of beat-count fields

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low; clock clk
req_valid  in  1  core presents a COP1 memory op; held stable while stall=1
req_store  in  1  1 = store (swc1/sdc1), 0 = load
req_beats  in  BEAT_W  word count (1 = single, 2 = double)
req_byte_addr  in  32  effective byte address (rs + imm)
req_freg  in  5  first FP register (Ft)
stall  out  1  core must hold PC and IR
done  out  1  1-cycle pulse on the final cycle of a transfer
err_misalign  out  1  1-cycle pulse; request rejected
mem_cen  out  1  chip enable, active-low (= mem_oen & mem_wen)
mem_wen  out  1  write enable, active-low
mem_oen  out  1  output enable, active-low
mem_a  out  ADDR_W  word address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data
freg_rd_idx  out  5  FP register-file read index (store source)
freg_rd_data  in  DATA_W  FP register-file read data
freg_we  out  1  FP register-file write enable
freg_wr_idx  out  5  FP register-file write index
freg_wr_data  out  DATA_W  FP register-file write data

Behaviour:
- Registered state: fsm {IDLE, XFER, DRAIN}, issue counter iss_k, capture counter cap_k (BEAT_W bits). All other outputs are combinational from state and request.
- Reset (rst_n=0 at posedge): fsm=IDLE, iss_k=cap_k=0. While in IDLE with req_valid=0, outputs are stall=0, done=0, err_misalign=0, mem_cen=mem_wen=mem_oen=1, freg_we=0.
- Reset mid-transfer: the sequence aborts at the edge. Beats already written remain. No done pulse.
- Beat k addressing: mem_a = req_byte_addr[ADDR_W+1:2] + k, modulo 2^ADDR_W (wraps). FP register = (req_freg + k) mod 32. Word k+1 goes to register Ft+1, matching ldc1/sdc1 ordering.
- The first beat issues in the same cycle req_valid is seen in IDLE (no bubble).
- Stores, any MEM_RD_LAT: N cycles.
  - Cycle k: mem_wen=0, freg_rd_idx=req_freg+k, mem_wdata=freg_rd_data.
  - stall=1 in cycles 0..N-2; stall=0 and done=1 in cycle N-1.
- Loads, MEM_RD_LAT=0: N cycles.
  - Cycle k: mem_oen=0, freg_we=1, freg_wr_data=mem_rdata, freg_wr_idx=req_freg+k.
  - stall and done as for stores.
- Loads, MEM_RD_LAT=1: N+1 cycles, pipelined.
  - Cycle k (k<N): issue beat k with mem_oen=0.
  - Cycle k+1: capture beat k (freg_we=1, idx=req_freg+cap_k), overlapped with the issue of beat k+1.
  - The last capture happens in DRAIN with mem_oen=1. stall=0 and done=1 in the DRAIN cycle.
- FSM transitions:
  - IDLE → XFER on an accepted request with N>1, or with N=1 and MEM_RD_LAT=1 load.
  - XFER → DRAIN after the last issue when a load has MEM_RD_LAT=1.
  - XFER/DRAIN → IDLE on the done cycle.
- req_beats=0: no memory access, done=1, stall=0, same cycle.
- req_beats>MAX_BEATS: err_misalign=1 and done=1 in the same cycle, no access, stall=0.
- Back-to-back: a new request presented in the cycle after done is accepted from IDLE normally.
- req_valid dropped while stall=1 is a protocol violation. Behaviour is undefined; the bench asserts it never happens.

Optional Feature:
COP1_SEQ_ALIGN_CHECK_EN
- Defined: a request is rejected (err_misalign=1, done=1, stall=0, no memory or register activity) when req_byte_addr[1:0]!=0, or when req_beats==2 and req_freg[0]==1 (odd double register).
- Undefined: address bits [1:0] are ignored, odd doubles are allowed, and err_misalign reports only the beats>MAX_BEATS case.

Decomposition:
- Package cop1_seq_pkg holds:
  - the fsm state enum;
  - localparams for beat count 1 (single) and 2 (double), and for the FP register count 32;
  - the function computing the beat-count width.
- One sub-module, cop1_seq_addr_gen: combinational base + k wrap for mem_a (ADDR_W) and the register index (5 bits). It is instantiated twice, for the issue and capture counters.

Test Plan:
- Single load, MEM_RD_LAT=0, addr 0x10, Ft=4, rdata 0x3F800000 → 1 cycle, mem_a=4, freg[4] written, done=1, stall=0.
- Double store, addr 0x20, Ft=6, freg6=0x40000000, freg7=0x0 → cycle 0: mem_a=8, wdata 0x40000000, stall=1; cycle 1: mem_a=9, wdata 0, done=1.
- Double load, MEM_RD_LAT=1, addr 0x1FC, ADDR_W=7 → mem_a 127 then 0 (wrap), writes to Ft and Ft+1 in cycles 1 and 2, stall=1 for 2 cycles, done in cycle 2.
- rst_n low in cycle 1 of a double load (lat 1) → next cycle IDLE, no done pulse, only beat 0 written, all memory strobes high.
- With COP1_SEQ_ALIGN_CHECK_EN: addr 0x22, or double with Ft=5 → err_misalign=1, done=1, CEN=1, freg_we=0.
- Back-to-back store (Ft=2) then load (Ft=2) at the same address, lat 0 → load returns the stored value, no idle cycle between done and the next accept.
